rhs_frame_packer: RTL and testbench

Downstream of the 256-channel RHS acquisition core. Takes one 16-port sample slot per chip-channel conversion (16 ports × 16 bits) and packs the slots into fixed-length 32-bit stream frames for the host DMA/FIFO: header, timestamp, 128 data words, trailer. A 2-entry slot FIFO decouples the SPI cadence from stream backpressure. Missing or dropped chip channels are replaced by filler words, so frame length stays constant.

---
 rtl/rhs_frame_packer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_rhs_frame_packer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_frame_packer.sv
// rhs_frame_packer: packs 16-port RHS sample slots into fixed 131-word
// stream frames (header, timestamp, 16 x 8 data words, trailer).
// A 2-entry slot FIFO absorbs stream backpressure; missing chip channels
// are replaced by filler words so every frame has the same length.
module rhs_frame_packer #(
  parameter int          CHIP_CHANNELS = 16,
  parameter logic [31:0] FILL_WORD     = 32'h8000_8000,
  parameter logic [15:0] HDR_MAGIC     = 16'hA5C3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         record_en,
  input  logic         in_valid,
  input  logic [3:0]   in_chip_channel,
  input  logic [255:0] in_data,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic [15:0]  overflow_count,
  output logic [15:0]  frame_count
);

  // The state names what the output register loads on the next free cycle.
  // SEL is the slot boundary where the select rule runs; END holds the
  // trailer until the consumer takes it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TS,
    ST_SEL,
    ST_SLOT,
    ST_FILL,
    ST_TRL,
    ST_END
  } state_t;

  localparam logic [3:0] LAST_CHAN = 4'(CHIP_CHANNELS - 1);

  // ---------------------------------------------------------------------
  // Slot FIFO (2 entries) and timestamp
  // ---------------------------------------------------------------------
  logic [3:0]   r_chan_mem [0:1];
  logic [31:0]  r_ts_mem   [0:1];
  logic [255:0] r_data_mem [0:1];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic [31:0]  r_ts;
  logic [15:0]  r_overflow;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_drop;
  logic         w_ts_inc;
  logic [31:0]  w_ts_new;
  logic [3:0]   w_head_chan;
  logic [31:0]  w_head_ts;
  logic [255:0] w_head_data;

  assign w_full      = (r_count == 2'd2);
  assign w_empty     = (r_count == 2'd0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push      = in_valid && record_en && (!w_full || w_pop);
  assign w_drop      = in_valid && record_en && !w_push;
  // Dropped channel-0 slots still advance time so gaps stay visible.
  assign w_ts_inc    = in_valid && record_en && (in_chip_channel == 4'd0);
  assign w_ts_new    = r_ts + {31'd0, w_ts_inc};
  assign w_head_chan = r_chan_mem[r_rptr];
  assign w_head_ts   = r_ts_mem[r_rptr];
  assign w_head_data = r_data_mem[r_rptr];

  // FIFO payload storage; pointers/count alone define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_chan_mem[r_wptr] <= in_chip_channel;
      r_ts_mem[r_wptr]   <= w_ts_new;
      r_data_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Timestamp counter and saturating drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ts       <= 32'd0;
      r_overflow <= 16'd0;
    end else begin
      r_ts <= w_ts_new;
      if (w_drop && (r_overflow != 16'hFFFF)) r_overflow <= r_overflow + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------
  state_t       r_state;
  logic [3:0]   r_exp;
  logic [2:0]   r_word;
  logic [31:0]  r_frame_ts;
  logic [15:0]  r_present;
  logic [7:0]   r_miss;
  logic [15:0]  r_frame_count;
  logic [31:0]  r_m_data;
  logic         r_m_valid;
  logic         r_m_last;

  state_t       w_state_next;
  logic [3:0]   w_exp_next;
  logic [2:0]   w_word_next;
  logic [31:0]  w_frame_ts_next;
  logic [15:0]  w_present_next;
  logic [7:0]   w_miss_next;
  logic [15:0]  w_frame_count_next;
  logic [31:0]  w_m_data_next;
  logic         w_m_valid_next;
  logic         w_m_last_next;

  logic         w_out_free;
  logic         w_hs;
  logic         w_sel_slot;
  logic         w_sel_fill;
  logic         w_exp_last;
  logic [7:0]   w_word_base;
  logic [31:0]  w_slot_word;

  assign w_out_free  = !r_m_valid || m_ready;
  assign w_hs        = r_m_valid && m_ready;
  assign w_exp_last  = (r_exp == LAST_CHAN);
  // Slot boundary decision: matching head is emitted; any other head
  // (later channel, or an early next-frame slot) or a stopped recording
  // means the expected channel is missing. Empty while recording waits.
  assign w_sel_slot  = !w_empty && (w_head_chan == r_exp);
  assign w_sel_fill  = (!w_empty && (w_head_chan != r_exp)) || (w_empty && !record_en);
  assign w_word_base = {r_word, 5'd0};
  assign w_slot_word = w_head_data[w_word_base +: 32];

  // Next-state and output-register computation.
  always_comb begin
    w_state_next       = r_state;
    w_exp_next         = r_exp;
    w_word_next        = r_word;
    w_frame_ts_next    = r_frame_ts;
    w_present_next     = r_present;
    w_miss_next        = r_miss;
    w_frame_count_next = r_frame_count;
    w_m_data_next      = r_m_data;
    w_m_valid_next     = w_hs ? 1'b0 : r_m_valid;
    w_m_last_next      = w_hs ? 1'b0 : r_m_last;
    w_pop              = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next    = ST_HDR;
          w_exp_next      = 4'd0;
          w_word_next     = 3'd0;
          w_frame_ts_next = w_head_ts;
          w_present_next  = 16'd0;
          w_miss_next     = 8'd0;
        end
      end

      ST_HDR: begin
        if (w_out_free) begin
          w_m_data_next  = {HDR_MAGIC, r_frame_count};
          w_m_valid_next = 1'b1;
          w_m_last_next  = 1'b0;
          w_state_next   = ST_TS;
        end
      end

      ST_TS: begin
        if (w_out_free) begin
          w_m_data_next  = r_frame_ts;
          w_m_valid_next = 1'b1;
          w_m_last_next  = 1'b0;
          w_state_next   = ST_SEL;
        end
      end

      ST_SEL: begin
        if (w_out_free) begin
          if (w_sel_slot) begin
            w_m_data_next  = w_head_data[31:0];
            w_m_valid_next = 1'b1;
            w_m_last_next  = 1'b0;
            w_word_next    = 3'd1;
            w_state_next   = ST_SLOT;
          end else if (w_sel_fill) begin
            w_m_data_next  = FILL_WORD;
            w_m_valid_next = 1'b1;
            w_m_last_next  = 1'b0;
            w_word_next    = 3'd1;
            w_state_next   = ST_FILL;
          end
        end
      end

      ST_SLOT: begin
        if (w_out_free) begin
          w_m_data_next  = w_slot_word;
          w_m_valid_next = 1'b1;
          w_m_last_next  = 1'b0;
          w_word_next    = r_word + 3'd1;
          if (r_word == 3'd7) begin
            // Head is consumed only once its last word is in the register.
            w_pop                 = 1'b1;
            w_present_next[r_exp] = 1'b1;
            w_exp_next            = r_exp + 4'd1;
            w_word_next           = 3'd0;
            w_state_next          = w_exp_last ? ST_TRL : ST_SEL;
          end
        end
      end

      ST_FILL: begin
        if (w_out_free) begin
          w_m_data_next  = FILL_WORD;
          w_m_valid_next = 1'b1;
          w_m_last_next  = 1'b0;
          w_word_next    = r_word + 3'd1;
          if (r_word == 3'd7) begin
            w_miss_next  = r_miss + 8'd1;
            w_exp_next   = r_exp + 4'd1;
            w_word_next  = 3'd0;
            w_state_next = w_exp_last ? ST_TRL : ST_SEL;
          end
        end
      end

      ST_TRL: begin
        if (w_out_free) begin
          w_m_data_next  = {8'h5A, r_miss, r_present};
          w_m_valid_next = 1'b1;
          w_m_last_next  = 1'b1;
          w_state_next   = ST_END;
        end
      end

      ST_END: begin
        // The frame only counts once the trailer has actually left.
        if (w_hs) begin
          w_frame_count_next = r_frame_count + 16'd1;
          w_state_next       = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Serializer state and registered stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_exp         <= 4'd0;
      r_word        <= 3'd0;
      r_frame_ts    <= 32'd0;
      r_present     <= 16'd0;
      r_miss        <= 8'd0;
      r_frame_count <= 16'd0;
      r_m_data      <= 32'd0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_exp         <= w_exp_next;
      r_word        <= w_word_next;
      r_frame_ts    <= w_frame_ts_next;
      r_present     <= w_present_next;
      r_miss        <= w_miss_next;
      r_frame_count <= w_frame_count_next;
      r_m_data      <= w_m_data_next;
      r_m_valid     <= w_m_valid_next;
      r_m_last      <= w_m_last_next;
    end
  end

  assign m_data         = r_m_data;
  assign m_valid        = r_m_valid;
  assign m_last         = r_m_last;
  assign overflow_count = r_overflow;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_rhs_frame_packer.sv
// tb_rhs_frame_packer: directed scenarios with a scoreboard of expected
// stream words; a monitor pops and compares on every handshake.
module tb_rhs_frame_packer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         record_en;
  logic         in_valid;
  logic [3:0]   in_chip_channel;
  logic [255:0] in_data;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [15:0]  overflow_count;
  logic [15:0]  frame_count;

  always #5 clk = ~clk;

  rhs_frame_packer dut (
    .clk             (clk),
    .rstn            (rstn),
    .record_en       (record_en),
    .in_valid        (in_valid),
    .in_chip_channel (in_chip_channel),
    .in_data         (in_data),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .overflow_count  (overflow_count),
    .frame_count     (frame_count)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  int          mon_words = 0;

  // Spec-level frame model state
  int          tb_ts = 0;
  int          tb_fc = 0;
  int          tb_exp = 0;
  int          tb_miss = 0;
  bit          tb_in_frame = 0;
  logic [15:0] tb_present = 16'd0;

  bit          hold_pend = 0;
  logic [31:0] hold_data;
  logic        hold_last;
  logic [32:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] mk(input int ch, input int tag);
    logic [255:0] d;
    logic [3:0]   c;
    logic [3:0]   t;
    logic [3:0]   k;
    c = ch[3:0];
    t = tag[3:0];
    d = '0;
    for (int i = 0; i < 8; i++) begin
      k = i[3:0];
      d[32*i +: 32] = {4'hD, t, c, k, 4'hE, t, c, k};
    end
    return d;
  endfunction

  function automatic void push(input logic last, input logic [31:0] w);
    exp_q.push_back({last, w});
  endfunction

  function automatic void model_trailer();
    push(1'b1, {8'h5A, tb_miss[7:0], tb_present});
    tb_fc++;
    tb_in_frame = 0;
  endfunction

  function automatic void model_fill_to(input int n);
    while (tb_exp < n) begin
      for (int k = 0; k < 8; k++) push(1'b0, 32'h8000_8000);
      tb_miss++;
      tb_exp++;
    end
  endfunction

  function automatic void model_close();
    model_fill_to(16);
    model_trailer();
  endfunction

  function automatic void model_start();
    push(1'b0, {16'hA5C3, tb_fc[15:0]});
    push(1'b0, tb_ts[31:0]);
    tb_in_frame = 1;
    tb_exp      = 0;
    tb_miss     = 0;
    tb_present  = 16'd0;
  endfunction

  function automatic void model_slot(input int ch, input logic [255:0] d);
    if (!tb_in_frame) begin
      model_start();
    end else if (ch < tb_exp) begin
      model_close();
      model_start();
    end
    model_fill_to(ch);
    for (int k = 0; k < 8; k++) push(1'b0, d[32*k +: 32]);
    tb_present[ch] = 1'b1;
    tb_exp++;
    if (tb_exp == 16) model_trailer();
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle slot pulse; updates the model first (output latency >= 2).
  task automatic pulse(input int ch, input bit accept, input int tag);
    logic [255:0] d;
    d = mk(ch, tag);
    if (record_en && ch == 0) tb_ts++;
    if (accept) model_slot(ch, d);
    in_valid        = 1'b1;
    in_chip_channel = ch[3:0];
    in_data         = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send(input int ch, input bit accept, input int tag);
    pulse(ch, accept, tag);
    tick(31);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    checks++;
    assert (n < 3000) else begin
      failures++;
      $error("FAIL %s_drain observed=timeout words_left=%0d expected=empty", tag, exp_q.size());
    end
  endtask

  // Monitor: compare every accepted word and check stall stability.
  always @(negedge clk) begin
    if (!rstn) begin
      hold_pend = 0;
      mon_words = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", m_data, hold_data);
        chk("hold_last", {31'd0, m_last}, {31'd0, hold_last});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_word observed=%h expected=none", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("word%0d_data", mon_words), m_data, mon_e[31:0]);
          chk($sformatf("word%0d_last", mon_words), {31'd0, m_last}, {31'd0, mon_e[32]});
          mon_words = m_last ? 0 : mon_words + 1;
        end
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn            = 1'b0;
    record_en       = 1'b0;
    in_valid        = 1'b0;
    in_chip_channel = 4'd0;
    in_data         = '0;
    m_ready         = 1'b1;
    tick(3);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_overflow", {16'd0, overflow_count}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    rstn = 1'b1;
    tick(2);

    // Nominal frame with first-header latency check
    $display("step nominal");
    record_en = 1'b1;
    pulse(0, 1'b1, 1);
    chk("lat_valid_c1", {31'd0, m_valid}, 32'd0);
    tick(1);
    chk("lat_valid_c2", {31'd0, m_valid}, 32'd0);
    tick(1);
    chk("lat_valid_c3", {31'd0, m_valid}, 32'd1);
    chk("lat_hdr", m_data, 32'hA5C3_0000);
    tick(29);
    for (int c = 1; c < 16; c++) send(c, 1'b1, 1);
    drain("nominal");
    chk("nominal_frame_count", {16'd0, frame_count}, 32'd1);
    chk("nominal_overflow", {16'd0, overflow_count}, 32'd0);

    // Gap: channel 5 missing
    $display("step gap");
    for (int c = 0; c < 16; c++) if (c != 5) send(c, 1'b1, 2);
    drain("gap");
    chk("gap_frame_count", {16'd0, frame_count}, 32'd2);

    // Backpressure: two slots buffered, three dropped
    $display("step backpressure");
    for (int c = 0; c < 3; c++) send(c, 1'b1, 3);
    m_ready = 1'b0;
    send(3, 1'b1, 3);
    send(4, 1'b1, 3);
    for (int c = 5; c < 8; c++) send(c, 1'b0, 3);
    tick(40);
    chk("bp_overflow", {16'd0, overflow_count}, 32'd3);
    chk("bp_stalled_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    tick(32);
    for (int c = 8; c < 16; c++) send(c, 1'b1, 3);
    drain("backpressure");
    chk("bp_frame_count", {16'd0, frame_count}, 32'd3);

    // Early frame: channel 0 arrives after channel 9
    $display("step early_frame");
    for (int c = 0; c < 10; c++) send(c, 1'b1, 4);
    for (int c = 0; c < 16; c++) send(c, 1'b1, 5);
    drain("early");
    chk("early_frame_count", {16'd0, frame_count}, 32'd5);

    // record_en drops after channel 3
    $display("step enable_drop");
    for (int c = 0; c < 4; c++) send(c, 1'b1, 6);
    model_close();
    record_en = 1'b0;
    drain("enable_drop");
    chk("en_frame_count", {16'd0, frame_count}, 32'd6);
    send(0, 1'b0, 6);
    send(7, 1'b0, 6);
    chk("en_ignored_valid", {31'd0, m_valid}, 32'd0);
    chk("en_overflow", {16'd0, overflow_count}, 32'd3);

    // Reset at word 50 while stalled
    $display("step reset_mid_frame");
    record_en = 1'b1;
    for (int c = 0; c < 6; c++) send(c, 1'b1, 7);
    pulse(6, 1'b1, 7);
    n = 0;
    while (mon_words < 50 && n < 200) begin
      tick(1);
      n++;
    end
    m_ready = 1'b0;
    chk("rst_reach_word50", n < 200 ? 32'd1 : 32'd0, 32'd1);
    tick(3);
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_last", {31'd0, m_last}, 32'd0);
    chk("mid_rst_m_data", m_data, 32'd0);
    chk("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_overflow", {16'd0, overflow_count}, 32'd0);
    exp_q.delete();
    tb_ts       = 0;
    tb_fc       = 0;
    tb_in_frame = 0;
    tick(2);
    rstn    = 1'b1;
    m_ready = 1'b1;
    tick(2);

    // Clean frame after reset
    $display("step after_reset");
    for (int c = 0; c < 16; c++) send(c, 1'b1, 8);
    drain("after_reset");
    chk("after_rst_frame_count", {16'd0, frame_count}, 32'd1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
